// File: rtl/mem_stage.sv
// mem_stage: MEM pipeline stage. Passes EXE results through to writeback and
// runs single outstanding word accesses against the data memory. The upstream
// pipeline is held while an access is in flight.
//
// Parameter:
//   TIMEOUT        max WAIT cycles without dmem_ack before abort (1..255)
//
// Ports:
//   clk, rst_n     clock; asynchronous active-low reset
//   mem_op         memory operation (MEM_NOP_OP / MEM_LW_OP / MEM_SW_OP / MEM_LB_OP)
//   mem_addr       effective byte address
//   mem_data       store data
//   ex_write_reg, ex_write_data, ex_we   writeback triple from EXE
//   dmem_req, dmem_we, dmem_addr, dmem_wdata   data-memory request (word aligned)
//   dmem_ack, dmem_rdata                       data-memory response
//   stall_req      hold all upstream stages this cycle
//   wb_write_reg, wb_write_data, wb_we         registered MEM/WB outputs
//   misalign_err, timeout_err                  sticky error flags
//
// Build option:
//   MEM_LB_EN      when defined, MEM_LB_OP is a sign-extended byte load at any
//                  alignment; otherwise it behaves as a NOP with no writeback.

`ifndef MEM_NOP_OP
`define MEM_NOP_OP 4'd0
`endif
`ifndef MEM_LW_OP
`define MEM_LW_OP 4'd1
`endif
`ifndef MEM_SW_OP
`define MEM_SW_OP 4'd2
`endif
`ifndef MEM_LB_OP
`define MEM_LB_OP 4'd3
`endif

module mem_stage #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  mem_op,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_data,
  input  logic [4:0]  ex_write_reg,
  input  logic [31:0] ex_write_data,
  input  logic        ex_we,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        stall_req,
  output logic [4:0]  wb_write_reg,
  output logic [31:0] wb_write_data,
  output logic        wb_we,
  output logic        misalign_err,
  output logic        timeout_err
);

  typedef enum logic {IDLE, WAIT} state_t;

  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

  state_t      r_state;
  state_t      w_nextState;
  logic [7:0]  r_waitCnt;
  logic [3:0]  r_op;
  logic [1:0]  r_offset;
  logic [4:0]  r_writeReg;
  logic        r_writeEn;
  logic [31:0] r_dmemAddr;
  logic [31:0] r_dmemWdata;
  logic [4:0]  r_wbReg;
  logic [31:0] r_wbData;
  logic        r_wbWe;
  logic        r_misalign;
  logic        r_timeout;

  logic        w_isLw;
  logic        w_isSw;
  logic        w_isLb;
  logic        w_lbStart;
  logic        w_aligned;
  logic        w_start;
  logic        w_misalign;
  logic        w_exWe;
  logic        w_timeoutHit;
  logic [7:0]  w_lbByte;
  logic [31:0] w_loadData;

  // Decode the incoming operation and decide whether it needs the memory.
  assign w_isLw     = (mem_op == `MEM_LW_OP);
  assign w_isSw     = (mem_op == `MEM_SW_OP);
  assign w_isLb     = (mem_op == `MEM_LB_OP);
  assign w_aligned  = (mem_addr[1:0] == 2'b00);
  assign w_misalign = (w_isLw || w_isSw) && !w_aligned;

`ifdef MEM_LB_EN
  assign w_lbStart = w_isLb;
`else
  assign w_lbStart = 1'b0;
`endif

  assign w_start = ((w_isLw || w_isSw) && w_aligned) || w_lbStart;

  // Register 0 is hardwired, so a write to it is never signalled.
  assign w_exWe = ex_we && (ex_write_reg != 5'd0);

  assign w_timeoutHit = (r_waitCnt == TIMEOUT_LAST);

  // Byte lane selection for byte loads (little-endian); only an LB access can
  // reach WAIT with r_op == MEM_LB_OP, which never happens without MEM_LB_EN.
  always_comb begin
    w_lbByte = dmem_rdata[7:0];
    case (r_offset)
      2'd0: w_lbByte = dmem_rdata[7:0];
      2'd1: w_lbByte = dmem_rdata[15:8];
      2'd2: w_lbByte = dmem_rdata[23:16];
      2'd3: w_lbByte = dmem_rdata[31:24];
      default: w_lbByte = dmem_rdata[7:0];
    endcase
  end

  assign w_loadData = (r_op == `MEM_LB_OP) ? {{24{w_lbByte[7]}}, w_lbByte} : dmem_rdata;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next state and request/stall outputs. The stall is released in the ack
  // cycle and in the abort cycle so upstream advances on that same edge; it
  // is gated by rst_n so reset forces it low immediately.
  always_comb begin
    w_nextState = r_state;
    stall_req   = 1'b0;
    dmem_req    = 1'b0;
    dmem_we     = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_start) begin
          w_nextState = WAIT;
          stall_req   = rst_n;
        end
      end
      WAIT: begin
        dmem_req = 1'b1;
        dmem_we  = (r_op == `MEM_SW_OP);
        if (dmem_ack || w_timeoutHit) begin
          w_nextState = IDLE;
        end else begin
          stall_req = rst_n;
        end
      end
      default: w_nextState = IDLE;
    endcase
  end

  // Access capture, wait counter, writeback registers and error flags.
  // Ack is checked before the timeout so a late ack still completes normally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_waitCnt   <= 8'd0;
      r_op        <= `MEM_NOP_OP;
      r_offset    <= 2'd0;
      r_writeReg  <= 5'd0;
      r_writeEn   <= 1'b0;
      r_dmemAddr  <= 32'd0;
      r_dmemWdata <= 32'd0;
      r_wbReg     <= 5'd0;
      r_wbData    <= 32'd0;
      r_wbWe      <= 1'b0;
      r_misalign  <= 1'b0;
      r_timeout   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_start) begin
            r_op        <= mem_op;
            r_dmemAddr  <= {mem_addr[31:2], 2'b00};
            r_offset    <= mem_addr[1:0];
            r_dmemWdata <= mem_data;
            r_writeReg  <= ex_write_reg;
            r_writeEn   <= w_exWe;
            r_waitCnt   <= 8'd0;
            r_wbWe      <= 1'b0;
          end else if (w_misalign) begin
            r_wbWe     <= 1'b0;
            r_misalign <= 1'b1;
          end else if (w_isLb) begin
            r_wbReg  <= ex_write_reg;
            r_wbData <= ex_write_data;
            r_wbWe   <= 1'b0;
          end else begin
            r_wbReg  <= ex_write_reg;
            r_wbData <= ex_write_data;
            r_wbWe   <= w_exWe;
          end
        end
        WAIT: begin
          if (dmem_ack) begin
            if (r_op == `MEM_SW_OP) begin
              r_wbWe <= 1'b0;
            end else begin
              r_wbReg  <= r_writeReg;
              r_wbData <= w_loadData;
              r_wbWe   <= r_writeEn;
            end
          end else if (w_timeoutHit) begin
            r_wbWe    <= 1'b0;
            r_timeout <= 1'b1;
          end else begin
            r_waitCnt <= r_waitCnt + 8'd1;
          end
        end
        default: r_wbWe <= 1'b0;
      endcase
    end
  end

  assign dmem_addr     = r_dmemAddr;
  assign dmem_wdata    = r_dmemWdata;
  assign wb_write_reg  = r_wbReg;
  assign wb_write_data = r_wbData;
  assign wb_we         = r_wbWe;
  assign misalign_err  = r_misalign;
  assign timeout_err   = r_timeout;

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed bench for mem_stage with TIMEOUT=4, checked every
// cycle against a transaction-level reference model plus literal checkpoints.

`ifndef MEM_NOP_OP
`define MEM_NOP_OP 4'd0
`endif
`ifndef MEM_LW_OP
`define MEM_LW_OP 4'd1
`endif
`ifndef MEM_SW_OP
`define MEM_SW_OP 4'd2
`endif
`ifndef MEM_LB_OP
`define MEM_LB_OP 4'd3
`endif

module tb_mem_stage;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  mem_op = 4'd0;
  logic [31:0] mem_addr = 32'd0;
  logic [31:0] mem_data = 32'd0;
  logic [4:0]  ex_write_reg = 5'd0;
  logic [31:0] ex_write_data = 32'd0;
  logic        ex_we = 1'b0;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic        dmem_ack = 1'b0;
  logic [31:0] dmem_rdata = 32'd0;
  logic        stall_req;
  logic [4:0]  wb_write_reg;
  logic [31:0] wb_write_data;
  logic        wb_we;
  logic        misalign_err;
  logic        timeout_err;

  int nCompared = 0;
  int nMismatched = 0;
  int stallCnt = 0;
  int reqCnt = 0;

  mem_stage #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .mem_op(mem_op), .mem_addr(mem_addr), .mem_data(mem_data),
    .ex_write_reg(ex_write_reg), .ex_write_data(ex_write_data), .ex_we(ex_we),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .stall_req(stall_req),
    .wb_write_reg(wb_write_reg), .wb_write_data(wb_write_data), .wb_we(wb_we),
    .misalign_err(misalign_err), .timeout_err(timeout_err)
  );

  // 10-unit clock; rising edges at 5, 15, 25 ...
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs on the falling edge, then tally stall/request.
  task automatic applyStimulus(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] data,
                               input logic [4:0] wreg, input logic [31:0] wdata, input logic we,
                               input logic ack, input logic [31:0] rdata);
    @(negedge clk);
    mem_op = op; mem_addr = addr; mem_data = data;
    ex_write_reg = wreg; ex_write_data = wdata; ex_we = we;
    dmem_ack = ack; dmem_rdata = rdata;
    #3;
    if (stall_req) stallCnt++;
    if (dmem_req) reqCnt++;
  endtask

  // Reference model: one pending access with a count of elapsed wait cycles.
  bit          mPend = 0;
  int          mCycles = 0;
  logic [3:0]  mOp = 4'd0;
  logic [31:0] mAddr = 32'd0;
  logic [31:0] mWdata = 32'd0;
  int          mOff = 0;
  logic [4:0]  mReg = 5'd0;
  bit          mWe = 0;
  logic [4:0]  mWbReg = 5'd0;
  logic [31:0] mWbData = 32'd0;
  bit          mWbWe = 0;
  bit          mMis = 0;
  bit          mTo = 0;
  logic        expStall;

  function automatic bit startsAccess(input logic [3:0] op, input logic [31:0] a);
    if ((op == `MEM_LW_OP || op == `MEM_SW_OP) && a[1:0] == 2'b00) return 1;
`ifdef MEM_LB_EN
    if (op == `MEM_LB_OP) return 1;
`endif
    return 0;
  endfunction

  function automatic logic [31:0] byteLoad(input logic [31:0] rdata, input int off);
    logic [7:0] b;
    b = rdata[8*off +: 8];
    return {{24{b[7]}}, b};
  endfunction

  // Advance the model on every rising edge; reset clears it at once.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mPend = 0; mCycles = 0; mWbReg = 5'd0; mWbData = 32'd0; mWbWe = 0; mMis = 0; mTo = 0;
    end else if (!mPend) begin
      if (startsAccess(mem_op, mem_addr)) begin
        mPend = 1; mCycles = 0; mOp = mem_op; mAddr = {mem_addr[31:2], 2'b00};
        mOff = int'(mem_addr[1:0]); mWdata = mem_data; mReg = ex_write_reg;
        mWe = ex_we && ex_write_reg != 0; mWbWe = 0;
      end else if ((mem_op == `MEM_LW_OP || mem_op == `MEM_SW_OP) && mem_addr[1:0] != 0) begin
        mWbWe = 0; mMis = 1;
      end else begin
        mWbReg = ex_write_reg; mWbData = ex_write_data;
        mWbWe = (mem_op == `MEM_LB_OP) ? 1'b0 : (ex_we && ex_write_reg != 0);
      end
    end else if (dmem_ack) begin
      mPend = 0;
      if (mOp == `MEM_SW_OP) mWbWe = 0;
      else begin
        mWbReg = mReg; mWbWe = mWe;
        mWbData = (mOp == `MEM_LB_OP) ? byteLoad(dmem_rdata, mOff) : dmem_rdata;
      end
    end else if (mCycles == TO - 1) begin
      mPend = 0; mWbWe = 0; mTo = 1;
    end else begin
      mCycles++;
    end
  end

  // Compare every output against the model each cycle, after inputs settle.
  always @(negedge clk) begin
    #2;
    expStall = rst_n && (mPend ? (!dmem_ack && mCycles != TO - 1) : startsAccess(mem_op, mem_addr));
    checkOutput("stall_req", {31'd0, stall_req}, {31'd0, expStall});
    checkOutput("dmem_req", {31'd0, dmem_req}, {31'd0, mPend});
    checkOutput("dmem_we", {31'd0, dmem_we}, {31'd0, mPend && mOp == `MEM_SW_OP});
    if (mPend) begin
      checkOutput("dmem_addr", dmem_addr, mAddr);
      checkOutput("dmem_wdata", dmem_wdata, mWdata);
    end
    checkOutput("wb_we", {31'd0, wb_we}, {31'd0, mWbWe});
    if (mWbWe) begin
      checkOutput("wb_write_reg", {27'd0, wb_write_reg}, {27'd0, mWbReg});
      checkOutput("wb_write_data", wb_write_data, mWbData);
    end
    checkOutput("misalign_err", {31'd0, misalign_err}, {31'd0, mMis});
    checkOutput("timeout_err", {31'd0, timeout_err}, {31'd0, mTo});
  end

  // Time limit so the run always ends.
  initial begin
    #20000;
    $display("[TB] FAIL watchdog: time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Directed scenarios with literal checkpoints.
  initial begin
    #3;
    checkOutput("rst_stall", {31'd0, stall_req}, 32'd0);
    checkOutput("rst_req", {31'd0, dmem_req}, 32'd0);
    checkOutput("rst_dmem_addr", dmem_addr, 32'd0);
    checkOutput("rst_wb_data", wb_write_data, 32'd0);
    checkOutput("rst_wb_reg", {27'd0, wb_write_reg}, 32'd0);
    checkOutput("rst_wb_we", {31'd0, wb_we}, 32'd0);
    checkOutput("rst_errs", {30'd0, misalign_err, timeout_err}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] ALU result passthrough");
    stallCnt = 0;
    applyStimulus(`MEM_NOP_OP, 32'd0, 32'd0, 5'd5, 32'h1234, 1'b1, 1'b0, 32'd0);
    applyStimulus(`MEM_NOP_OP, 32'd0, 32'd0, 5'd0, 32'h5555, 1'b1, 1'b0, 32'd0);
    checkOutput("add_wb_reg", {27'd0, wb_write_reg}, 32'd5);
    checkOutput("add_wb_data", wb_write_data, 32'h1234);
    checkOutput("add_wb_we", {31'd0, wb_we}, 32'd1);
    applyStimulus(`MEM_NOP_OP, 32'd0, 32'd0, 5'd6, 32'd0, 1'b0, 1'b0, 32'd0);
    checkOutput("r0_wb_we", {31'd0, wb_we}, 32'd0);
    checkOutput("add_no_stall", stallCnt, 32'd0);

    $display("[TB] LW with ack on the fourth wait cycle");
    stallCnt = 0; reqCnt = 0;
    applyStimulus(`MEM_LW_OP, 32'h104, 32'd0, 5'd8, 32'h77, 1'b1, 1'b0, 32'd0);
    applyStimulus(`MEM_LW_OP, 32'h104, 32'd0, 5'd8, 32'h77, 1'b1, 1'b0, 32'd0);
    checkOutput("lw_dmem_addr", dmem_addr, 32'h104);
    applyStimulus(`MEM_LW_OP, 32'h104, 32'd0, 5'd8, 32'h77, 1'b1, 1'b0, 32'd0);
    applyStimulus(`MEM_LW_OP, 32'h104, 32'd0, 5'd8, 32'h77, 1'b1, 1'b0, 32'd0);
    applyStimulus(`MEM_LW_OP, 32'h104, 32'd0, 5'd8, 32'h77, 1'b1, 1'b1, 32'hDEADBEEF);
    checkOutput("lw_ack_stall", {31'd0, stall_req}, 32'd0);
    applyStimulus(`MEM_NOP_OP, 32'd0, 32'd0, 5'd0, 32'd0, 1'b0, 1'b1, 32'h11111111);
    checkOutput("lw_wb_data", wb_write_data, 32'hDEADBEEF);
    checkOutput("lw_wb_reg", {27'd0, wb_write_reg}, 32'd8);
    checkOutput("lw_wb_we", {31'd0, wb_we}, 32'd1);
    checkOutput("lw_stall_cycles", stallCnt, 32'd4);
    checkOutput("lw_req_cycles", reqCnt, 32'd4);
    checkOutput("lw_no_timeout", {31'd0, timeout_err}, 32'd0);

    $display("[TB] aligned SW");
    applyStimulus(`MEM_NOP_OP, 32'd0, 32'd0, 5'd2, 32'h42, 1'b1, 1'b0, 32'd0);
    applyStimulus(`MEM_SW_OP, 32'h200, 32'hCAFEF00D, 5'd4, 32'd0, 1'b1, 1'b0, 32'd0);
    applyStimulus(`MEM_SW_OP, 32'h200, 32'hCAFEF00D, 5'd4, 32'd0, 1'b1, 1'b0, 32'd0);
    checkOutput("sw_dmem_we", {31'd0, dmem_we}, 32'd1);
    checkOutput("sw_dmem_wdata", dmem_wdata, 32'hCAFEF00D);
    checkOutput("sw_dmem_addr", dmem_addr, 32'h200);
    applyStimulus(`MEM_SW_OP, 32'h200, 32'hCAFEF00D, 5'd4, 32'd0, 1'b1, 1'b1, 32'd0);
    applyStimulus(`MEM_NOP_OP, 32'd0, 32'd0, 5'd0, 32'd0, 1'b0, 1'b0, 32'd0);
    checkOutput("sw_wb_we", {31'd0, wb_we}, 32'd0);

    $display("[TB] misaligned SW");
    applyStimulus(`MEM_NOP_OP, 32'd0, 32'd0, 5'd3, 32'h99, 1'b1, 1'b0, 32'd0);
    stallCnt = 0; reqCnt = 0;
    applyStimulus(`MEM_SW_OP, 32'h102, 32'hAA, 5'd3, 32'h99, 1'b1, 1'b0, 32'd0);
    applyStimulus(`MEM_NOP_OP, 32'd0, 32'd0, 5'd0, 32'd0, 1'b0, 1'b0, 32'd0);
    checkOutput("mis_err", {31'd0, misalign_err}, 32'd1);
    checkOutput("mis_wb_we", {31'd0, wb_we}, 32'd0);
    checkOutput("mis_req", reqCnt, 32'd0);
    checkOutput("mis_stall", stallCnt, 32'd0);

    $display("[TB] LW timeout");
    stallCnt = 0; reqCnt = 0;
    applyStimulus(`MEM_LW_OP, 32'h300, 32'd0, 5'd10, 32'd0, 1'b1, 1'b0, 32'd0);
    for (int i = 0; i < 4; i++)
      applyStimulus(`MEM_LW_OP, 32'h300, 32'd0, 5'd10, 32'd0, 1'b1, 1'b0, 32'd0);
    checkOutput("to_stall_release", {31'd0, stall_req}, 32'd0);
    applyStimulus(`MEM_NOP_OP, 32'd0, 32'd0, 5'd0, 32'd0, 1'b0, 1'b0, 32'd0);
    checkOutput("to_err", {31'd0, timeout_err}, 32'd1);
    checkOutput("to_wb_we", {31'd0, wb_we}, 32'd0);
    checkOutput("to_req_cycles", reqCnt, 32'd4);
    checkOutput("to_stall_cycles", stallCnt, 32'd4);

    $display("[TB] LB");
`ifdef MEM_LB_EN
    applyStimulus(`MEM_LB_OP, 32'h203, 32'd0, 5'd9, 32'd0, 1'b1, 1'b0, 32'd0);
    applyStimulus(`MEM_LB_OP, 32'h203, 32'd0, 5'd9, 32'd0, 1'b1, 1'b1, 32'h80FFFFFF);
    applyStimulus(`MEM_NOP_OP, 32'd0, 32'd0, 5'd0, 32'd0, 1'b0, 1'b0, 32'd0);
    checkOutput("lb3_wb_data", wb_write_data, 32'hFFFFFF80);
    checkOutput("lb3_wb_we", {31'd0, wb_we}, 32'd1);
    applyStimulus(`MEM_LB_OP, 32'h201, 32'd0, 5'd11, 32'd0, 1'b1, 1'b0, 32'd0);
    applyStimulus(`MEM_LB_OP, 32'h201, 32'd0, 5'd11, 32'd0, 1'b1, 1'b1, 32'h12347F56);
    applyStimulus(`MEM_NOP_OP, 32'd0, 32'd0, 5'd0, 32'd0, 1'b0, 1'b0, 32'd0);
    checkOutput("lb1_wb_data", wb_write_data, 32'h0000007F);
    checkOutput("lb1_wb_reg", {27'd0, wb_write_reg}, 32'd11);
`else
    applyStimulus(`MEM_NOP_OP, 32'd0, 32'd0, 5'd9, 32'h1, 1'b1, 1'b0, 32'd0);
    stallCnt = 0; reqCnt = 0;
    applyStimulus(`MEM_LB_OP, 32'h203, 32'd0, 5'd9, 32'h2, 1'b1, 1'b0, 32'd0);
    applyStimulus(`MEM_NOP_OP, 32'd0, 32'd0, 5'd0, 32'd0, 1'b0, 1'b0, 32'd0);
    checkOutput("lb_off_wb_we", {31'd0, wb_we}, 32'd0);
    checkOutput("lb_off_req", reqCnt, 32'd0);
    checkOutput("lb_off_stall", stallCnt, 32'd0);
`endif

    $display("[TB] reset during WAIT");
    applyStimulus(`MEM_LW_OP, 32'h400, 32'd0, 5'd7, 32'd0, 1'b1, 1'b0, 32'd0);
    applyStimulus(`MEM_LW_OP, 32'h400, 32'd0, 5'd7, 32'd0, 1'b1, 1'b0, 32'd0);
    rst_n = 1'b0;
    #1;
    checkOutput("rw_req", {31'd0, dmem_req}, 32'd0);
    checkOutput("rw_stall", {31'd0, stall_req}, 32'd0);
    checkOutput("rw_dmem_addr", dmem_addr, 32'd0);
    checkOutput("rw_wb", {wb_write_reg, wb_we, 26'd0}, 32'd0);
    checkOutput("rw_errs", {30'd0, misalign_err, timeout_err}, 32'd0);
    @(negedge clk);
    mem_op = `MEM_NOP_OP; ex_we = 1'b0; ex_write_reg = 5'd0; dmem_ack = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    reqCnt = 0;
    applyStimulus(`MEM_NOP_OP, 32'd0, 32'd0, 5'd0, 32'd0, 1'b0, 1'b1, 32'hFFFFFFFF);
    applyStimulus(`MEM_NOP_OP, 32'd0, 32'd0, 5'd0, 32'd0, 1'b0, 1'b0, 32'd0);
    checkOutput("rw_after_wb_we", {31'd0, wb_we}, 32'd0);
    checkOutput("rw_after_req", reqCnt, 32'd0);
    applyStimulus(`MEM_NOP_OP, 32'd0, 32'd0, 5'd0, 32'd0, 1'b0, 1'b0, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
